// File: rtl/eth_fcs_pkg.sv
// Shared constants and types for the Ethernet FCS datapath (CRC-32, reflected).
package eth_fcs_pkg;

  localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_PASS} state_t;

  // Bit-reverse a 32-bit word; turns the normal polynomial into its reflected form.
  function automatic logic [31:0] reflect32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/eth_fcs_check_rx_lfsr.sv
// Combinational CRC-32 byte update, Galois configuration, reflected (LSB-first data).
module lfsr
  import eth_fcs_pkg::*;
#(
  parameter logic [31:0] POLY = CRC32_POLY
) (
  input  logic [31:0] crc,
  input  logic [7:0]  data,
  output logic [31:0] crc_next
);

  localparam logic [31:0] POLY_REFL = reflect32(POLY);

  logic [31:0] acc;

  // Shift the eight data bits through the reflected register, LSB first.
  always_comb begin
    acc = crc;
    for (int i = 0; i < 8; i++) begin
      if (acc[0] ^ data[i]) acc = (acc >> 1) ^ POLY_REFL;
      else                  acc = acc >> 1;
    end
    crc_next = acc;
  end

endmodule

// File: rtl/eth_fcs_check_rx.sv
// Receive-side Ethernet FCS checker: strips the 4-byte FCS, flags bad frames
// on tuser, drops runts. Optional statistics counters: ETH_FCS_CHECK_STATS_EN.
module eth_fcs_check_rx
  import eth_fcs_pkg::*;
#(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [31:0] CRC_INIT    = CRC32_INIT,
  parameter logic [31:0] CRC_RESIDUE = CRC32_RESIDUE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  error_bad_fcs,
  output logic                  error_bad_frame
`ifdef ETH_FCS_CHECK_STATS_EN
  ,
  output logic [31:0]           stat_good_frames,
  output logic [31:0]           stat_bad_frames
`endif
);

  if (DATA_WIDTH != 8) begin : g_width_check
    $error("eth_fcs_check_rx: DATA_WIDTH must be 8");
  end

  state_t                state, state_next;
  logic [1:0]            cnt, cnt_next;
  logic [31:0]           crc, crc_next;
  logic [DATA_WIDTH-1:0] dly [4];
  logic                  accept;
  logic                  fcs_bad;
  logic                  load_out;
  logic                  frame_end;
  logic                  runt;

  assign s_axis_tready = m_axis_tready | ~m_axis_tvalid;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign fcs_bad       = (crc_next != CRC_RESIDUE);

  lfsr #(.POLY(CRC32_POLY)) u_lfsr (
    .crc      (crc),
    .data     (s_axis_tdata),
    .crc_next (crc_next)
  );

  // FSM state and fill-count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 2'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic: fill the delay line, pass payload, detect end of frame and runts.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    load_out   = 1'b0;
    frame_end  = 1'b0;
    runt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (s_axis_tlast) begin
            runt = 1'b1;
          end else begin
            state_next = ST_FILL;
            cnt_next   = 2'd1;
          end
        end
      end
      ST_FILL: begin
        if (accept) begin
          if (s_axis_tlast) begin
            runt       = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
          end else if (cnt == 2'd3) begin
            state_next = ST_PASS;
          end else begin
            cnt_next = cnt + 2'd1;
          end
        end
      end
      ST_PASS: begin
        if (accept) begin
          load_out = 1'b1;
          if (s_axis_tlast) begin
            frame_end  = 1'b1;
            state_next = ST_IDLE;
            cnt_next   = 2'd0;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Running CRC: advance per accepted byte, restart at every frame boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= CRC_INIT;
    end else if (frame_end | runt) begin
      crc <= CRC_INIT;
    end else if (accept) begin
      crc <= crc_next;
    end
  end

  // Four-byte delay line holding back the FCS; dly[3] is the oldest byte.
  always_ff @(posedge clk) begin
    if (accept) begin
      dly[0] <= s_axis_tdata;
      for (int i = 1; i < 4; i++) dly[i] <= dly[i-1];
    end
  end

  // Output register and error pulses; holds the beat while the sink stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_axis_tvalid   <= 1'b0;
      m_axis_tdata    <= '0;
      m_axis_tlast    <= 1'b0;
      m_axis_tuser    <= 1'b0;
      error_bad_fcs   <= 1'b0;
      error_bad_frame <= 1'b0;
    end else begin
      error_bad_fcs   <= frame_end & fcs_bad;
      error_bad_frame <= runt;
      if (load_out) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= dly[3];
        m_axis_tlast  <= frame_end;
        m_axis_tuser  <= frame_end & (s_axis_tuser | fcs_bad);
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

`ifdef ETH_FCS_CHECK_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

  // Saturating good/bad frame counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_good_frames <= 32'd0;
      stat_bad_frames  <= 32'd0;
    end else begin
      if (frame_end & ~s_axis_tuser & ~fcs_bad) stat_good_frames <= sat_inc(stat_good_frames);
      if ((frame_end & fcs_bad) | runt)         stat_bad_frames  <= sat_inc(stat_bad_frames);
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
